// File: rtl/kbd_pkg.sv
// kbd_pkg
//   Shared definitions for the PS/2 Set-2 scan-code decoder: decoder state
//   enum, prefix bytes, bytes the decoder ignores, and the table of
//   game-control keys whose pressed state is tracked.
//   No ports (package).

package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE_ST,
        EXT_ST,
        BRK_ST,
        EXT_BRK_ST,
        PAUSE_ST
    } kbd_state_t;

    // Prefix bytes
    localparam logic [7:0] KBD_EXT   = 8'hE0;
    localparam logic [7:0] KBD_BRK   = 8'hF0;
    localparam logic [7:0] KBD_PAUSE = 8'hE1;

    // Keyboard status/response bytes that carry no key information
    localparam logic [7:0] KBD_BAT_OK  = 8'hAA;
    localparam logic [7:0] KBD_ACK     = 8'hFA;
    localparam logic [7:0] KBD_RESEND  = 8'hFE;
    localparam logic [7:0] KBD_ECHO    = 8'hEE;
    localparam logic [7:0] KBD_ERR_LO  = 8'h00;
    localparam logic [7:0] KBD_ERR_HI  = 8'hFF;

    // Shift codes the keyboard injects around some extended keys
    localparam logic [7:0] KBD_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] KBD_FAKE_RSHIFT = 8'h59;

    localparam int KBD_NUM_TRACKED = 8;

    // Tracked keys, index i maps to key_down[i]; bit8 is the E0 flag.
    // Concatenation is written MSB first, so entry 7 comes first.
    localparam logic [KBD_NUM_TRACKED-1:0][8:0] KBD_TRACKED = {
        9'h01D,   // 7 W
        9'h076,   // 6 ESC
        9'h05A,   // 5 ENTER
        9'h029,   // 4 SPACE
        9'h174,   // 3 RIGHT
        9'h16B,   // 2 LEFT
        9'h172,   // 1 DOWN
        9'h175    // 0 UP
    };

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == KBD_BAT_OK) || (b == KBD_ACK) || (b == KBD_RESEND) ||
               (b == KBD_ECHO) || (b == KBD_ERR_LO) || (b == KBD_ERR_HI);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == KBD_FAKE_LSHIFT) || (b == KBD_FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/kbd_key_tracker.sv
// kbd_key_tracker
//   Holds the pressed-state bitmap of the tracked game-control keys.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous active-high reset
//     ev_code   in   9-bit code of the event being decoded this cycle
//     ev_make   in   event is a make (press / typematic repeat)
//     ev_break  in   event is a break (release)
//     key_down  out  pressed state, bit i = KBD_TRACKED entry i

module kbd_key_tracker
    import kbd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] ev_code,
    input  logic       ev_make,
    input  logic       ev_break,
    output logic [7:0] key_down
);

    logic [KBD_NUM_TRACKED-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < KBD_NUM_TRACKED; i++) begin
            hit[i] = (ev_code == KBD_TRACKED[i]);
        end
    end

    // Inputs are the unregistered decode results, so the bitmap lands in
    // the same cycle as the registered key_make/key_break pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_down <= 8'h00;
        end else if (ev_make) begin
            key_down <= key_down | hit;
        end else if (ev_break) begin
            key_down <= key_down & ~hit;
        end
    end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// kbd_scancode_decoder
//   Decodes PS/2 Set-2 make/break/extended byte sequences into single key
//   events and tracks the pressed state of the game-control keys.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-high reset
//     din[7:0]   in   byte from the PS/2 receiver, valid when din_new=1
//     din_new    in   one-cycle strobe for a new byte
//     key_code   out  last decoded key {E0 flag, scan code}, held
//     key_make   out  one-cycle pulse: key_code pressed (incl. repeats)
//     key_break  out  one-cycle pulse: key_code released
//     key_down   out  pressed bitmap of the tracked keys
//     seq_error  out  one-cycle pulse: prefix sequence timed out

module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 1_000_000,
    parameter int PAUSE_SKIP_BYTES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic [8:0] key_code,
    output logic       key_make,
    output logic       key_break,
    output logic [7:0] key_down,
    output logic       seq_error
);

    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SKIP_W = $clog2(PAUSE_SKIP_BYTES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    kbd_state_t        state, state_nxt;
    logic              ext, ext_nxt;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_cnt_nxt;
    logic              ev_make, ev_break, ev_tmo;
    logic [8:0]        ev_code;
    logic              in_prefix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE_ST;
            ext       <= 1'b0;
            tmo_cnt   <= '0;
            skip_cnt  <= '0;
            key_code  <= 9'h000;
            key_make  <= 1'b0;
            key_break <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            ext       <= ext_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            skip_cnt  <= skip_cnt_nxt;
            key_make  <= ev_make;
            key_break <= ev_break;
            seq_error <= ev_tmo;
            if (ev_make || ev_break) begin
                key_code <= ev_code;
            end
        end
    end

    assign in_prefix = (state == EXT_ST) || (state == BRK_ST) || (state == EXT_BRK_ST);

    always_comb begin
        state_nxt    = state;
        ext_nxt      = ext;
        tmo_cnt_nxt  = '0;
        skip_cnt_nxt = skip_cnt;
        ev_make      = 1'b0;
        ev_break     = 1'b0;
        ev_tmo       = 1'b0;
        ev_code      = {ext, din};

        case (state)
            IDLE_ST: begin
                if (din_new) begin
                    if (din == KBD_EXT) begin
                        state_nxt = EXT_ST;
                        ext_nxt   = 1'b1;
                    end else if (din == KBD_BRK) begin
                        state_nxt = BRK_ST;
                    end else if (din == KBD_PAUSE) begin
                        state_nxt    = PAUSE_ST;
                        skip_cnt_nxt = SKIP_W'(PAUSE_SKIP_BYTES);
                    end else if (!is_ignored(din)) begin
                        ev_make = 1'b1;
                        ev_code = {1'b0, din};
                    end
                end
            end

            EXT_ST: begin
                if (din_new) begin
                    if (din == KBD_BRK) begin
                        state_nxt = EXT_BRK_ST;
                    end else if (din == KBD_EXT) begin
                        state_nxt = EXT_ST;
                    end else begin
                        state_nxt = IDLE_ST;
                        ext_nxt   = 1'b0;
                        if (!is_fake_shift(din)) begin
                            ev_make = 1'b1;
                            ev_code = {1'b1, din};
                        end
                    end
                end
            end

            BRK_ST: begin
                if (din_new) begin
                    state_nxt = IDLE_ST;
                    ext_nxt   = 1'b0;
                    ev_break  = 1'b1;
                    ev_code   = {1'b0, din};
                end
            end

            EXT_BRK_ST: begin
                if (din_new) begin
                    state_nxt = IDLE_ST;
                    ext_nxt   = 1'b0;
                    if (!is_fake_shift(din)) begin
                        ev_break = 1'b1;
                        ev_code  = {1'b1, din};
                    end
                end
            end

            PAUSE_ST: begin
                // The Pause key has no break code; its tail bytes are dropped
                if (din_new) begin
                    skip_cnt_nxt = skip_cnt - 1'b1;
                    if (skip_cnt <= SKIP_W'(1)) begin
                        state_nxt = IDLE_ST;
                    end
                end
            end

            default: begin
                state_nxt = IDLE_ST;
                ext_nxt   = 1'b0;
            end
        endcase

        // An arriving byte always clears the counter (default above), so a
        // byte landing in the expiry cycle cancels the timeout.
        if (in_prefix && !din_new) begin
            if (tmo_cnt == TMO_LAST) begin
                ev_tmo    = 1'b1;
                state_nxt = IDLE_ST;
                ext_nxt   = 1'b0;
            end else begin
                tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
        end
    end

    kbd_key_tracker u_tracker (
        .clk      (clk),
        .reset    (reset),
        .ev_code  (ev_code),
        .ev_make  (ev_make),
        .ev_break (ev_break),
        .key_down (key_down)
    );

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
// tb_kbd_scancode_decoder
//   Self-checking bench: directed vector table, hand-written timeout and
//   reset sequences, then random byte streams against a sequence-matching
//   reference model.

module tb_kbd_scancode_decoder;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_new;
    logic [8:0] key_code;
    logic       key_make;
    logic       key_break;
    logic [7:0] key_down;
    logic       seq_error;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] din;
        logic       mk;
        logic       br;
        logic [8:0] code;
        logic [7:0] down;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [7:0] m_pend[$];
    int         m_pause;
    logic [8:0] m_code;
    logic [7:0] m_down;
    logic [8:0] trk[8] = '{9'h175, 9'h172, 9'h16B, 9'h174,
                           9'h029, 9'h05A, 9'h076, 9'h01D};

    kbd_scancode_decoder #(
        .TIMEOUT_CYCLES   (TMO),
        .PAUSE_SKIP_BYTES (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_new   (din_new),
        .key_code  (key_code),
        .key_make  (key_make),
        .key_break (key_break),
        .key_down  (key_down),
        .seq_error (seq_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Strobe one byte; returns 1 time unit after the edge that samples it
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        din     = b;
        din_new = 1'b1;
        @(posedge clk);
        #1;
        din_new = 1'b0;
    endtask

    task automatic checkPulsesLow(input string name);
        @(posedge clk);
        #1;
        checkOutput(name, {29'd0, key_make, key_break, seq_error}, 32'd0);
    endtask

    function automatic vec_t mkv(input logic [7:0] d, input logic mk, input logic br,
                                 input logic [8:0] code, input logic [7:0] down);
        vec_t v;
        v.din = d; v.mk = mk; v.br = br; v.code = code; v.down = down;
        return v;
    endfunction

    function automatic logic isIgnored(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    function automatic logic isFakeShift(input logic [7:0] b);
        return b inside {8'h12, 8'h59};
    endfunction

    // Model: accumulate a pending prefix sequence and emit an event once the
    // buffered bytes form a complete make/break pattern.
    task automatic modelByte(input logic [7:0] b, output logic mk, output logic br);
        logic [8:0] code;
        mk = 1'b0; br = 1'b0; code = '0;
        if (m_pause > 0) begin
            m_pause--;
            return;
        end
        m_pend.push_back(b);
        if (m_pend.size() == 1) begin
            if (b == 8'hE1) begin
                m_pause = 7;
                m_pend.delete();
            end else if (b != 8'hE0 && b != 8'hF0) begin
                if (!isIgnored(b)) begin mk = 1'b1; code = {1'b0, b}; end
                m_pend.delete();
            end
        end else if (m_pend[0] == 8'hF0) begin
            br = 1'b1; code = {1'b0, b};
            m_pend.delete();
        end else if (m_pend.size() == 2) begin
            if (b == 8'hE0) begin
                void'(m_pend.pop_back());
            end else if (b != 8'hF0) begin
                if (!isFakeShift(b)) begin mk = 1'b1; code = {1'b1, b}; end
                m_pend.delete();
            end
        end else begin
            if (!isFakeShift(b)) begin br = 1'b1; code = {1'b1, b}; end
            m_pend.delete();
        end
        if (mk || br) begin
            m_code = code;
            for (int i = 0; i < 8; i++) begin
                if (trk[i] == code) m_down[i] = mk;
            end
        end
    endtask

    function automatic logic [7:0] randByte();
        int r;
        logic [8:0] t;
        r = $urandom_range(0, 99);
        t = trk[$urandom_range(0, 7)];
        if (r < 30)      return t[7:0];
        else if (r < 45) return 8'hE0;
        else if (r < 60) return 8'hF0;
        else if (r < 63) return 8'hE1;
        else if (r < 68) return 8'hAA;
        else if (r < 73) return (r[0] ? 8'h12 : 8'h59);
        else             return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic mk, br;
        logic [7:0] b;
        int early;

        reset   = 1'b1;
        din     = 8'h00;
        din_new = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_code",  {23'd0, key_code}, 32'h000);
        checkOutput("reset_pulse", {29'd0, key_make, key_break, seq_error}, 32'd0);
        checkOutput("reset_down",  {24'd0, key_down}, 32'h00);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        vecs.push_back(mkv(8'h1D, 1, 0, 9'h01D, 8'h80));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h01D, 8'h80));
        vecs.push_back(mkv(8'h1D, 0, 1, 9'h01D, 8'h00));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h01D, 8'h00));
        vecs.push_back(mkv(8'h75, 1, 0, 9'h175, 8'h01));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h175, 8'h01));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h175, 8'h01));
        vecs.push_back(mkv(8'h75, 0, 1, 9'h175, 8'h00));
        vecs.push_back(mkv(8'h29, 1, 0, 9'h029, 8'h10));
        vecs.push_back(mkv(8'h29, 1, 0, 9'h029, 8'h10));
        vecs.push_back(mkv(8'h29, 1, 0, 9'h029, 8'h10));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h029, 8'h10));
        vecs.push_back(mkv(8'h29, 0, 1, 9'h029, 8'h00));
        vecs.push_back(mkv(8'hE1, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'h14, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'h77, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'hE1, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'h14, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'h77, 0, 0, 9'h029, 8'h00));
        vecs.push_back(mkv(8'h76, 1, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'hAA, 0, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'h12, 0, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h076, 8'h40));
        vecs.push_back(mkv(8'h6B, 1, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'h59, 0, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'hE0, 0, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'hF0, 0, 0, 9'h16B, 8'h44));
        vecs.push_back(mkv(8'h6B, 0, 1, 9'h16B, 8'h40));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].din);
            checkOutput($sformatf("vec%0d_make", i),  {31'd0, key_make},  {31'd0, vecs[i].mk});
            checkOutput($sformatf("vec%0d_break", i), {31'd0, key_break}, {31'd0, vecs[i].br});
            checkOutput($sformatf("vec%0d_code", i),  {23'd0, key_code},  {23'd0, vecs[i].code});
            checkOutput($sformatf("vec%0d_down", i),  {24'd0, key_down},  {24'd0, vecs[i].down});
            checkOutput($sformatf("vec%0d_serr", i),  {31'd0, seq_error}, 32'd0);
            checkPulsesLow($sformatf("vec%0d_pulse_clear", i));
        end

        // Timeout after a lone E0: pulse visible after the TMO-th edge
        applyStimulus(8'hE0);
        early = 0;
        for (int k = 1; k < TMO; k++) begin
            @(posedge clk);
            #1;
            if (seq_error || key_make || key_break) early++;
        end
        checkOutput("tmo_no_early_pulse", early, 0);
        @(posedge clk);
        #1;
        checkOutput("tmo_seq_error", {31'd0, seq_error}, 32'd1);
        checkOutput("tmo_no_event", {30'd0, key_make, key_break}, 32'd0);
        checkPulsesLow("tmo_pulse_clear");
        applyStimulus(8'h5A);
        checkOutput("after_tmo_make", {31'd0, key_make}, 32'd1);
        checkOutput("after_tmo_code", {23'd0, key_code}, 32'h05A);
        checkOutput("after_tmo_down", {24'd0, key_down}, 32'h60);
        checkPulsesLow("after_tmo_clear");

        // Byte arriving in the expiry cycle wins over the timeout
        applyStimulus(8'hE0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        applyStimulus(8'h75);
        checkOutput("race_serr", {31'd0, seq_error}, 32'd0);
        checkOutput("race_make", {31'd0, key_make}, 32'd1);
        checkOutput("race_code", {23'd0, key_code}, 32'h175);
        checkOutput("race_down", {24'd0, key_down}, 32'h61);
        checkPulsesLow("race_clear");

        // Reset between E0 and 6B
        applyStimulus(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_code", {23'd0, key_code}, 32'h000);
        checkOutput("midrst_down", {24'd0, key_down}, 32'h00);
        checkOutput("midrst_pulse", {29'd0, key_make, key_break, seq_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h6B);
        checkOutput("midrst_make", {31'd0, key_make}, 32'd1);
        checkOutput("midrst_6b_code", {23'd0, key_code}, 32'h06B);
        checkOutput("midrst_6b_down", {24'd0, key_down}, 32'h00);
        checkPulsesLow("midrst_clear");

        // Random stream against the reference model
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_pend.delete();
        m_pause = 0;
        m_code  = 9'h000;
        m_down  = 8'h00;
        for (int n = 0; n < 300; n++) begin
            b = randByte();
            modelByte(b, mk, br);
            applyStimulus(b);
            checkOutput($sformatf("rnd%0d_make", n),  {31'd0, key_make},  {31'd0, mk});
            checkOutput($sformatf("rnd%0d_break", n), {31'd0, key_break}, {31'd0, br});
            checkOutput($sformatf("rnd%0d_code", n),  {23'd0, key_code},  {23'd0, m_code});
            checkOutput($sformatf("rnd%0d_down", n),  {24'd0, key_down},  {24'd0, m_down});
            checkOutput($sformatf("rnd%0d_serr", n),  {31'd0, seq_error}, 32'd0);
            checkPulsesLow($sformatf("rnd%0d_clear", n));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kbd_scancode_decoder.md
Name: kbd_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes validated bytes (8-bit data plus a one-cycle new-byte strobe) and decodes PS/2 Set-2 make/break/extended sequences into single key events.
- Maintains a pressed-state bitmap for the game-control keys used by the billiard logic.
- Recovers from truncated prefix sequences with a timeout.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: clk cycles (20 ms at 50 MHz) allowed between prefix bytes before the sequence is abandoned.
- PAUSE_SKIP_BYTES, 7: bytes discarded after an E1 (Pause key) prefix.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- din  input  8  byte from the receiver, valid when din_new=1
- din_new  input  1  one-cycle strobe: new valid byte on din
- key_code  output  9  last decoded key, bit8=extended (E0) flag, bits7:0=scan code
- key_make  output  1  one-cycle pulse: key_code pressed (includes typematic repeats)
- key_break  output  1  one-cycle pulse: key_code released
- key_down  output  8  pressed state of the tracked keys, index per package table
- seq_error  output  1  one-cycle pulse: prefix sequence timed out

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE_ST, ext=0, timeout counter=0, skip counter=0.
  - key_code=9'h000, key_make=0, key_break=0, key_down=8'h00, seq_error=0.
- All outputs are registered.
- Event latency: key_make/key_break assert in the cycle after the din_new cycle that completes a sequence; key_code updates in that same cycle and holds until the next event.
- Bytes are consumed only when din_new=1. No back-pressure; the receiver guarantees at least 2 cycles between strobes.
- States:
  - IDLE_ST:
    - E0 -> EXT_ST.
    - F0 -> BRK_ST.
    - E1 -> PAUSE_ST, skip counter=PAUSE_SKIP_BYTES.
    - AA/FA/FE/EE/00/FF: ignored, stay in IDLE_ST.
    - Any other byte: make event, code={0,din}.
  - EXT_ST:
    - F0 -> EXT_BRK_ST.
    - 12 or 59 (fake shift): ignored -> IDLE_ST.
    - E0: stay in EXT_ST.
    - Any other byte: make event, code={1,din} -> IDLE_ST.
  - BRK_ST: any byte -> break event, code={0,din} -> IDLE_ST.
  - EXT_BRK_ST:
    - 12 or 59: ignored -> IDLE_ST.
    - Any other byte: break event, code={1,din} -> IDLE_ST.
  - PAUSE_ST: each byte decrements the skip counter. When it reaches 0 -> IDLE_ST. No events are emitted, and no timeout applies.
- Timeout:
  - In EXT_ST, BRK_ST and EXT_BRK_ST, the counter increments every cycle without din_new and clears on each din_new.
  - When the counter reaches TIMEOUT_CYCLES-1: seq_error pulses 1 cycle, state -> IDLE_ST, no key event.
  - If din_new arrives in the same cycle as the timeout, the byte wins and the timeout is cancelled.
- key_down:
  - On a make whose code matches tracked entry i, set bit i.
  - On a break that matches entry i, clear bit i.
  - A repeated make of an already-set key still pulses key_make, and the bit stays 1.
  - Untracked codes leave key_down unchanged.
- key_make and key_break are never asserted together.
- Counter width: $clog2(TIMEOUT_CYCLES+1).

Decomposition:
- Package kbd_pkg contains:
  - state enum.
  - Prefix constants: KBD_EXT=8'hE0, KBD_BRK=8'hF0, KBD_PAUSE=8'hE1.
  - Ignore-list constants.
  - 8-entry tracked-key table of 9-bit codes:
    - 0 UP=E075, 1 DOWN=E072, 2 LEFT=E06B, 3 RIGHT=E074
    - 4 SPACE=029, 5 ENTER=05A, 6 ESC=076, 7 W=01D
- One sub-module, kbd_key_tracker: takes the event code and pulses, and holds the key_down bitmap.
- The top level holds the FSM and the timeout counter.

Test Plan:
- Reset, then din=1D strobe -> one cycle later key_make=1, key_code=9'h01D, key_down=8'h80. Then F0,1D -> key_break=1, key_down=8'h00.
- E0,75 -> key_make, key_code=9'h175, key_down[0]=1. Then E0,F0,75 -> key_break, key_code=9'h175, key_down[0]=0.
- Typematic: 29,29,29 -> three key_make pulses with key_code=9'h029, key_down[4] stays 1; then F0,29 clears it.
- E0 followed by no byte for TIMEOUT_CYCLES (set to 100 in bench) -> seq_error pulse at cycle 100, no event. A following 5A gives a non-extended make of 9'h05A.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> no events, no seq_error. A following 76 gives a make of 9'h076, key_down[6]=1.
- Assert reset between E0 and 6B -> all outputs 0. A subsequent 6B decodes as non-extended 9'h06B, and key_down is unchanged.
